// File: rtl/rom_arbiter.sv
// Two-requester arbiter (instruction cache / data port) sharing one ROM read port.
// Grant to completion takes N+3 cycles for an N-cycle ROM busy; the loser and all waiting requesters see busy=1.
module rom_arbiter #(
  parameter bit FIXED_PRIORITY = 1'b0,
  parameter int TIMEOUT        = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ic_enable,
  input  logic [63:0] ic_addr,
  output logic [63:0] ic_data,
  output logic        ic_busy,
  input  logic        dp_enable,
  input  logic [63:0] dp_addr,
  output logic [63:0] dp_data,
  output logic        dp_busy,
  output logic        mem_enable,
  output logic [63:0] mem_addr,
  input  logic [63:0] mem_data,
  input  logic        mem_busy,
  output logic        mem_error
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic OWN_IC = 1'b0;
  localparam logic OWN_DP = 1'b1;

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;

  state_t        state;
  state_t        next_state;
  logic          owner;
  logic          last_owner;
  logic [CW-1:0] count;
  logic          grant_dp;
  logic          timeout_hit;

  assign timeout_hit = (count == CW'(TIMEOUT));

  // Round-robin hands a tie to whoever was not served last.
  always_comb begin
    grant_dp = dp_enable;
    if (ic_enable && dp_enable) begin
      grant_dp = FIXED_PRIORITY ? 1'b0 : (last_owner == OWN_IC);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (ic_enable || dp_enable) next_state = ISSUE;
      ISSUE:   next_state = WAIT;
      WAIT:    if (!mem_busy || timeout_hit) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    mem_enable = (state == ISSUE);
    ic_busy    = ic_enable && !((state == DONE) && (owner == OWN_IC));
    dp_busy    = dp_enable && !((state == DONE) && (owner == OWN_DP));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      owner      <= OWN_IC;
      last_owner <= OWN_DP;
      mem_addr   <= '0;
      count      <= '0;
      ic_data    <= '0;
      dp_data    <= '0;
      mem_error  <= 1'b0;
    end else begin
      mem_error <= 1'b0;
      case (state)
        IDLE: begin
          if (ic_enable || dp_enable) begin
            owner    <= grant_dp;
            mem_addr <= grant_dp ? dp_addr : ic_addr;
          end
        end
        ISSUE: count <= '0;
        WAIT: begin
          // A response arriving on the timeout cycle still counts as data.
          if (!mem_busy) begin
            if (owner == OWN_DP) dp_data <= mem_data;
            else                 ic_data <= mem_data;
          end else if (timeout_hit) begin
            if (owner == OWN_DP) dp_data <= '0;
            else                 ic_data <= '0;
            mem_error <= 1'b1;
          end else begin
            count <= count + CW'(1);
          end
        end
        DONE:    last_owner <= owner;
        default: ;
      endcase
    end
  end

endmodule
